ppu_write_queue: RTL

Bus-side initiator for the PPU register/memory slave port. It buffers CPU writes (address/data pairs) in a FIFO at any time and replays them into `ppu_top` only during vertical blank, using the PPU's `irq`/vblank as the go signal. Tile buffer, graphics, palette and OAM updates therefore land between frames and never tear. It sits between the HPS lightweight bridge and `ppu_top`, drives the PPU's `address`/`write_data`/`write`/`chipselect`, and consumes its `irq`.

---
 rtl/ppu_pkg.sv | 31 +++
 rtl/ppu_cmd_fifo.sv | 71 +++++++
 rtl/ppu_write_queue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU write queue: FSM states, bus widths
// and the layout of the CPU-visible status word.
package ppu_pkg;

    localparam int PPU_ADDR_W     = 12;
    localparam int PPU_DATA_W     = 32;
    localparam int STAT_OVF       = 31;
    localparam int STAT_STATE_LSB = 16;
    localparam int STAT_COUNT_W   = 11;

    typedef enum logic [1:0] {
        WAIT_VBLANK = 2'd0,
        DRAIN       = 2'd1,
        DONE        = 2'd2
    } queue_state_t;

    // Packs overflow, FSM state and fill level into the 32-bit status word.
    function automatic logic [31:0] build_status(
        input logic                    ovf,
        input queue_state_t            st,
        input logic [STAT_COUNT_W-1:0] cnt
    );
        logic [31:0] w_word;
        w_word                          = 32'd0;
        w_word[STAT_OVF]                = ovf;
        w_word[STAT_STATE_LSB +: 2]     = st;
        w_word[STAT_COUNT_W-1:0]        = cnt;
        return w_word;
    endfunction

endpackage

// File: rtl/ppu_cmd_fifo.sv
// Single-clock command FIFO with wrap-bit pointers; the storage array has no
// reset and a registered read port so it maps onto block RAM.
module ppu_cmd_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = PPU_ADDR_W + PPU_DATA_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [PW-1:0]    o_count
);

    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count    = r_wr_ptr - r_rd_ptr;
    assign o_full     = (o_count == FULL_CNT);
    assign o_empty    = (o_count == {PW{1'b0}});
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;
    assign o_pop_data = r_rd_data;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Pointer update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered read port; holds the last popped entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= {WIDTH{1'b0}};
        end else if (w_do_pop) begin
            r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

endmodule

// File: rtl/ppu_write_queue.sv
// Buffers CPU writes to the PPU and replays them only during vertical blank,
// so tile, palette and OAM updates never land mid-frame.
module ppu_write_queue
    import ppu_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = PPU_ADDR_W,
    parameter int DATA_W = PPU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_chipselect,
    input  logic              s_write,
    input  logic              s_read,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_write_data,
    output logic [31:0]       s_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_write_data,
    output logic              m_write,
    output logic              m_chipselect,
    input  logic              irq,
    output logic              done
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    queue_state_t              r_state;
    logic                      r_irq_q;
    logic                      r_overflow;
    logic                      r_m_write;
    logic                      r_done;
    logic [31:0]               r_readdata;

    logic                      w_push_req;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_read;
    logic                      w_pop;
    logic                      w_irq_rise;
    logic                      w_full;
    logic                      w_empty;
    logic [CNT_W-1:0]          w_count;
    logic [ADDR_W+DATA_W-1:0]  w_pop_data;

    // Fullness is judged on the pre-edge count, so a push alongside a pop at
    // full is still dropped.
    assign w_push_req = s_chipselect & s_write;
    assign w_push     = w_push_req & ~w_full;
    assign w_drop     = w_push_req & w_full;
    assign w_read     = s_chipselect & s_read;
    assign w_irq_rise = irq & ~r_irq_q;
    assign w_pop      = (r_state == DRAIN) & irq & ~w_empty;

    ppu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data ({s_address, s_write_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // The FIFO read register doubles as the master address/data register.
    assign m_address    = w_pop_data[ADDR_W+DATA_W-1:DATA_W];
    assign m_write_data = w_pop_data[DATA_W-1:0];
    assign m_write      = r_m_write;
    assign m_chipselect = r_m_write;
    assign done         = r_done;
    assign s_readdata   = r_readdata;

    // Vblank FSM with registered write strobe and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= WAIT_VBLANK;
            r_irq_q   <= 1'b0;
            r_m_write <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_irq_q   <= irq;
            r_m_write <= w_pop;
            r_done    <= 1'b0;
            case (r_state)
                WAIT_VBLANK: begin
                    if (w_irq_rise) begin
                        r_state <= DRAIN;
                    end else begin
                        r_state <= WAIT_VBLANK;
                    end
                end
                DRAIN: begin
                    // A push into an empty queue keeps us draining so it
                    // issues on the next cycle.
                    if (!irq) begin
                        r_state <= WAIT_VBLANK;
                    end else if (w_empty && !w_push) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                DONE: begin
                    if (!irq) begin
                        r_state <= WAIT_VBLANK;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= WAIT_VBLANK;
                end
            endcase
        end
    end

    // Sticky overflow and status capture; a drop wins over a clearing read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_readdata <= 32'd0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_read) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
            if (w_read) begin
                r_readdata <= build_status(r_overflow, r_state, STAT_COUNT_W'(w_count));
            end else begin
                r_readdata <= r_readdata;
            end
        end
    end

endmodule
